// File: rtl/mux16_rr_arbiter_pkg.sv
// Shared constants and types for the 16-source round-robin mux arbiter.
package mux16_pkg;

  localparam int N_SRC = 16;
  localparam int SEL_W = 4;
  localparam int CNT_W = 8;

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

endpackage

// File: rtl/mux16_rr_arbiter_if.sv
// Request/grant bundle between the requesters and the arbiter driving the 16:1 mux select.
interface mux16_rr_arbiter_if;
  import mux16_pkg::*;

  logic [N_SRC-1:0] req;
  logic             done;
  logic [SEL_W-1:0] sel;
  logic [N_SRC-1:0] grant;
  logic             busy;

  modport master (output req, done, input sel, grant, busy);
  modport slave  (input req, done, output sel, grant, busy);

endinterface

// File: rtl/mux16_rr_arbiter_pick.sv
// Combinational round-robin search: first set request starting at ptr, wrapping modulo 16.
module mux16_rr_pick
  import mux16_pkg::*;
(
  input  logic [N_SRC-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  // Walk from the farthest offset back to ptr so the nearest hit is the one that sticks.
  always_comb begin
    found = 1'b0;
    idx   = ptr;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      if (req[ptr + SEL_W'(k)]) begin
        found = 1'b1;
        idx   = ptr + SEL_W'(k);
      end
    end
  end

endmodule

// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter producing a registered select and one-hot grant for a 16:1 mux.
module mux16_rr_arbiter
  import mux16_pkg::*;
#(
  parameter int HOLD_MAX = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  mux16_rr_arbiter_if.slave  bus
);

  state_t           r_state;
  logic [SEL_W-1:0] r_ptr;
  logic [SEL_W-1:0] r_sel;
  logic [CNT_W-1:0] r_cnt;
  logic [N_SRC-1:0] r_grant;
  logic             r_busy;

  state_t           w_nextState;
  logic [SEL_W-1:0] w_nextPtr;
  logic [SEL_W-1:0] w_nextSel;
  logic [CNT_W-1:0] w_nextCnt;
  logic [N_SRC-1:0] w_nextGrant;
  logic             w_nextBusy;

  logic [SEL_W-1:0] w_pickPtr;
  logic             w_found;
  logic [SEL_W-1:0] w_idx;
  logic             w_release;

  // While granting, the search only matters on release, where ptr becomes sel+1 at the same edge.
  assign w_pickPtr = (r_state == GRANT) ? (r_sel + SEL_W'(1)) : r_ptr;
  assign w_release = bus.done || !bus.req[r_sel] || (r_cnt == CNT_W'(HOLD_MAX - 1));

  mux16_rr_pick u_pick (
    .req   (bus.req),
    .ptr   (w_pickPtr),
    .found (w_found),
    .idx   (w_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_sel   <= '0;
      r_cnt   <= '0;
      r_grant <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_ptr   <= w_nextPtr;
      r_sel   <= w_nextSel;
      r_cnt   <= w_nextCnt;
      r_grant <= w_nextGrant;
      r_busy  <= w_nextBusy;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_nextPtr   = r_ptr;
    w_nextSel   = r_sel;
    w_nextCnt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_nextState = GRANT;
          w_nextSel   = w_idx;
          w_nextCnt   = '0;
        end
      end
      GRANT: begin
        if (w_release) begin
          w_nextPtr = r_sel + SEL_W'(1);
          w_nextCnt = '0;
          if (w_found) begin
            w_nextSel = w_idx;
          end else begin
            w_nextState = IDLE;
          end
        end else begin
          w_nextCnt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  always_comb begin
    w_nextBusy  = (w_nextState == GRANT);
    w_nextGrant = '0;
    if (w_nextState == GRANT) begin
      w_nextGrant = N_SRC'(1) << w_nextSel;
    end
  end

  assign bus.sel   = r_sel;
  assign bus.grant = r_grant;
  assign bus.busy  = r_busy;

endmodule

// File: doc/mux16_rr_arbiter.md
MUX16_RR_ARBITER -- requirements
Module: mux16_rr_arbiter

Interface
REQ-001 SHALL have parameter HOLD_MAX, default 8, giving the maximum grant tenure in cycles (legal range 1..255).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port req, input, 16 bits: request from each of the 16 sources feeding the 16:1 mux; bit i = in[i] requester.
REQ-005 SHALL have port done, input, 1 bit: current holder releases the mux this cycle.
REQ-006 SHALL have port sel, output, 4 bits: registered select driving the 16:1 mux sel input.
REQ-007 SHALL have port grant, output, 16 bits: registered one-hot grant, equal to 1<<sel when busy, else all zero.
REQ-008 SHALL have port busy, output, 1 bit: registered; high while a grant is active.

Function
REQ-009 SHALL implement two states: IDLE (busy=0, grant=0) and GRANT (busy=1).
REQ-010 SHALL keep sel at its last granted value while in IDLE.
REQ-011 SHALL keep a 4-bit round-robin pointer ptr: the index with highest priority at the next arbitration.
REQ-012 Arbitration SHALL pick the first set req bit searching ptr, ptr+1, ... 15, 0, ... ptr-1, with modulo-16 wrap.
REQ-013 In IDLE with req != 0 at a clock edge, the block SHALL enter GRANT at that edge with sel = winner; grant is visible one cycle after req is sampled.
REQ-014 In IDLE with req == 0, the block SHALL stay in IDLE and all outputs SHALL hold.
REQ-015 In GRANT, an 8-bit tenure counter SHALL be 0 in the first grant cycle and increment by 1 each following cycle.
REQ-016 The grant SHALL be released at an edge where any of these holds: done=1; req[sel]=0; counter == HOLD_MAX-1.
REQ-017 On release, ptr SHALL update to sel+1 (15 wraps to 0).
- Arbitration then reruns at that same edge using the new ptr and the current req, with no bubble cycle.
REQ-018 On release, if a winner exists, the block SHALL stay in GRANT with the new sel and the counter cleared to 0; otherwise it SHALL go to IDLE with grant=0.
REQ-019 On release, the previous holder SHALL be eligible again only at lowest priority; a sole requester that is still requesting is re-granted back-to-back.
REQ-020 done asserted in IDLE SHALL be ignored.
REQ-021 Changes to req bits other than req[sel] during GRANT SHALL NOT affect sel or grant until release.
REQ-022 HOLD_MAX=1 SHALL force a release every cycle, rotating among all active requesters.

Reset
REQ-023 While rst_n=0, the block SHALL asynchronously force state=IDLE, ptr=0, sel=0, grant=0, busy=0 and counter=0.
REQ-024 Reset asserted mid-tenure SHALL drop grant immediately without waiting for a clock edge.
REQ-025 The first arbitration after reset SHALL use ptr=0.
REQ-026 Release of reset SHALL be assumed synchronous to clk, with no same-cycle output change beyond the reset values.

Structure
REQ-027 Package mux16_pkg SHALL hold:
- N_SRC=16 and SEL_W=4;
- the state type {IDLE, GRANT};
- the counter width constant (8).
REQ-028 A purely combinational sub-module mux16_rr_pick SHALL perform the search: inputs req[15:0] and ptr[3:0]; outputs found and idx[3:0].
REQ-029 The controller SHALL instantiate mux16_rr_pick once.
REQ-030 sel SHALL connect directly to the existing sixteentoonemux sel input; no combinational path SHALL run from req or done to sel or grant.

Verification
REQ-031 Reset then req=16'h0000 for 5 cycles -> busy=0, grant=0, sel=0 throughout.
REQ-032 req=16'h8001 held, done pulsed once per tenure:
- sel sequence 0, 15, 0, 15;
- grant sequence 0x0001, 0x8000, 0x0001, 0x8000.
REQ-033 req=16'h0010 held, no done, HOLD_MAX=8 -> sel=4 for 8 cycles, then re-granted sel=4 with counter=0 and busy continuously high.
REQ-034 req=16'h0024, sel=2 holder drops req[2] -> next cycle sel=5, grant=0x0020; when req[5] drops and req=0 -> IDLE, busy=0, sel stays 5.
REQ-035 rst_n low mid-tenure with sel=9 -> grant=0 and busy=0 before the next edge; after release with req=16'h0200, first grant is sel=9.
REQ-036 done=1 in IDLE with req=0 -> no state change; random req stress -> grant always one-hot or zero, and no requester starves beyond 15 tenures.
